// File: rtl/opb_register_simulink2ppc_capture_if.sv
// OPB slave-side bus bundle for the Simulink-to-PPC capture register.
// Master drives OPB_* request signals; slave returns Sl_* responses.
interface opb_register_simulink2ppc_capture_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_capture.sv
// Fabric-to-PPC capture register: fabric pushes 32-bit words, PPC reads over OPB.
// Ports: OPB_Clk/OPB_Rst_n, opb (OPB slave bundle), user_data_in/user_data_valid
// (capture strobe), user_freeze (ctrl bit0 exported to fabric).
// Map: +0 DATA(RO) +4 STATUS{ovr,new}(RO) +8 CTRL{clr,frz} +C COUNT(RO).
module opb_register_simulink2ppc_capture #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_01FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                                    OPB_Clk,
    input  logic                                    OPB_Rst_n,
    opb_register_simulink2ppc_capture_if.slave      opb,
    input  logic [31:0]                             user_data_in,
    input  logic                                    user_data_valid,
    output logic                                    user_freeze
);

    localparam bit IsV5 = (C_FAMILY == "virtex5");

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_AWIDTH-1:0] off;
    logic [C_OPB_DWIDTH-1:0] wdata;
    logic [C_OPB_DWIDTH-1:0] rmux;
    logic [1:0]              idx;
    logic                    hit;
    logic                    in_regs;
    logic                    xfer;
    logic                    rd;
    logic                    wr;
    logic                    rd_data;
    logic                    rd_stat;
    logic                    wr_ctrl;
    logic                    clr;
    logic                    accept;
    logic                    set_ovr;

    logic                    ack_q, ack_d;
    logic [31:0]             dbus_q, dbus_d;
    logic [31:0]             data_q, data_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    new_q, new_d;
    logic                    ovr_q, ovr_d;
    logic                    frz_q, frz_d;

    // OPB bit 31 is the integer LSB, so a plain copy keeps numeric value.
    assign addr  = opb.OPB_ABus;
    assign wdata = opb.OPB_DBus;
    assign off   = addr - C_BASEADDR;
    assign idx   = addr[3:2];

    assign hit = opb.OPB_select
              && (addr >= C_BASEADDR)
              && (addr <= C_HIGHADDR);

    // Only the first four words are real registers; the rest of the window
    // reads zero and swallows writes.
    assign in_regs = (off[C_OPB_AWIDTH-1:4] == '0);

    // A new transfer starts only when no ack is outstanding, which makes a
    // held select re-ack every other cycle.
    assign xfer = hit && !ack_q;
    assign rd   = xfer && opb.OPB_RNW;
    assign wr   = xfer && !opb.OPB_RNW;

    assign rd_data = rd && in_regs && (idx == 2'd0);
    assign rd_stat = rd && in_regs && (idx == 2'd1);
    assign wr_ctrl = wr && in_regs && (idx == 2'd2) && opb.OPB_BE[3];
    assign clr     = wr_ctrl && wdata[1];

    assign accept = user_data_valid && !frz_q;

    // A DATA read racing an accept hands the old word out, so the fresh word
    // is not an overrun.
    assign set_ovr = accept && new_q && !rd_data;

    always_comb begin
        rmux = '0;
        if (in_regs) begin
            unique case (idx)
                2'd0: rmux = data_q;
                2'd1: rmux = {30'b0, ovr_q, new_q};
                2'd2: rmux = {31'b0, frz_q};
                2'd3: rmux = cnt_q;
            endcase
        end
    end

    always_comb begin
        ack_d  = xfer;
        dbus_d = rd ? rmux : '0;

        data_d = accept ? user_data_in : data_q;

        new_d = new_q;
        if (accept) begin
            new_d = 1'b1;
        end else if (rd_data) begin
            new_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (set_ovr) begin
            ovr_d = 1'b1;
        end else if (rd_stat) begin
            ovr_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 32'd1;
        end

        frz_d = wr_ctrl ? wdata[0] : frz_q;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q  <= 1'b0;
            dbus_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            frz_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            dbus_q <= dbus_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            new_q  <= new_d;
            ovr_q  <= ovr_d;
            frz_q  <= frz_d;
        end
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;
    assign user_freeze    = frz_q;

    logic unused;
    assign unused = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], wdata[31:2],
                      off[3:0], IsV5};

endmodule

// File: tb/tb_opb_register_simulink2ppc_capture.sv
// Testbench for opb_register_simulink2ppc_capture.
// Table-driven bus ops with a read-data scoreboard, plus hand sequences.
module tb_opb_register_simulink2ppc_capture;

    localparam logic [31:0] A_DATA = 32'h0100_0100;
    localparam logic [31:0] A_STAT = 32'h0100_0104;
    localparam logic [31:0] A_CTRL = 32'h0100_0108;
    localparam logic [31:0] A_CNT  = 32'h0100_010C;
    localparam logic [31:0] A_RSV  = 32'h0100_0110;
    localparam logic [31:0] A_OUT  = 32'h0100_0200;
    localparam logic [31:0] A_LOW  = 32'h0100_00FC;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_CAP = 2;
    localparam int K_NAK = 3;
    localparam int K_FRZ = 4;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          cap;
        logic [31:0] cd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] v;
        int          id;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] udata;
    logic        uvalid;
    logic        ufrz;

    int tests;
    int fails;

    vec_t vl[$];
    sb_t  sbq[$];

    opb_register_simulink2ppc_capture_if bus ();

    opb_register_simulink2ppc_capture dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .opb            (bus.slave),
        .user_data_in   (udata),
        .user_data_valid(uvalid),
        .user_freeze    (ufrz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got %08h want %08h", nm, id, act, exp);
        end
    endtask

    // Every ack pops one expected read value (writes expect 0 on the bus).
    always @(negedge clk) begin
        if (rst_n && bus.Sl_xferAck) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got ack want none");
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("rdata", e.id, bus.Sl_DBus, e.v);
            end
        end
    end

    function automatic vec_t mk(int k, logic [31:0] a, logic [3:0] be,
                                logic [31:0] wd, bit c, logic [31:0] cd,
                                logic [31:0] e);
        vec_t r;
        r.kind = k; r.addr = a; r.be = be; r.wd = wd;
        r.cap = c;  r.cd = cd;  r.exp = e;
        return r;
    endfunction

    task automatic xfer(input bit rnw, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input bit c, input logic [31:0] cd,
                        input logic [31:0] e, input int id);
        @(negedge clk);
        bus.OPB_ABus   = a;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wd;
        bus.OPB_RNW    = rnw;
        bus.OPB_select = 1'b1;
        if (c) begin
            udata  = cd;
            uvalid = 1'b1;
        end
        sbq.push_back('{v: (rnw ? e : 32'h0), id: id});
        @(posedge clk);
        #1;
        chk("ack", id, {31'b0, bus.Sl_xferAck}, 32'd1);
        uvalid = 1'b0;
        @(negedge clk);
        bus.OPB_select = 1'b0;
    endtask

    task automatic capture(input logic [31:0] d);
        @(negedge clk);
        udata  = d;
        uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0;
    endtask

    task automatic noack(input logic [31:0] a, input int id);
        @(negedge clk);
        bus.OPB_ABus   = a;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        chk("noack", id, {31'b0, bus.Sl_xferAck}, 32'd0);
        @(negedge clk);
        bus.OPB_select = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        udata = '0;
        uvalid = 1'b0;
        bus.OPB_ABus = '0;
        bus.OPB_BE = '0;
        bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0;
        bus.OPB_select = 1'b0;
        bus.OPB_seqAddr = 1'b0;

        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_RD,  A_CNT,  4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_FRZ, 0,      0,    0, 0, 0, 32'h0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'hDEADBEEF, 0));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h1));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'hDEADBEEF));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h11111111, 0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h22222222, 0));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h3));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'h22222222));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_RD,  A_CNT,  4'hF, 0, 0, 0, 32'h3));
        vl.push_back(mk(K_WR,  A_CTRL, 4'b0001, 32'h1, 0, 0, 0));
        vl.push_back(mk(K_FRZ, 0,      0,    0, 0, 0, 32'h1));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h33333333, 0));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'h22222222));
        vl.push_back(mk(K_RD,  A_CNT,  4'hF, 0, 0, 0, 32'h3));
        vl.push_back(mk(K_RD,  A_CTRL, 4'hF, 0, 0, 0, 32'h1));
        vl.push_back(mk(K_WR,  A_CTRL, 4'b1110, 32'h0, 0, 0, 0));
        vl.push_back(mk(K_FRZ, 0,      0,    0, 0, 0, 32'h1));
        vl.push_back(mk(K_WR,  A_CTRL, 4'b0001, 32'h0, 0, 0, 0));
        vl.push_back(mk(K_FRZ, 0,      0,    0, 0, 0, 32'h0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h55555555, 0));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 1, 32'h44444444, 32'h55555555));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h1));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'h44444444));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h66666666, 0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'h77777777, 0));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 1, 32'h88888888, 32'h3));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h3));
        vl.push_back(mk(K_RD,  A_STAT, 4'hF, 0, 0, 0, 32'h1));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'h88888888));
        vl.push_back(mk(K_RD,  A_CNT,  4'hF, 0, 0, 0, 32'h8));
        vl.push_back(mk(K_WR,  A_CTRL, 4'b0001, 32'h2, 1, 32'h99999999, 0));
        vl.push_back(mk(K_RD,  A_CNT,  4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_RD,  A_CTRL, 4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_RD,  A_DATA, 4'hF, 0, 0, 0, 32'h99999999));
        vl.push_back(mk(K_WR,  A_RSV,  4'hF, 32'hFFFFFFFF, 0, 0, 0));
        vl.push_back(mk(K_RD,  A_RSV,  4'hF, 0, 0, 0, 32'h0));
        vl.push_back(mk(K_NAK, A_OUT,  0,    0, 0, 0, 0));
        vl.push_back(mk(K_NAK, A_LOW,  0,    0, 0, 0, 0));
        vl.push_back(mk(K_CAP, 0,      0,    0, 1, 32'hABCD0123, 0));

        repeat (3) @(negedge clk);
        chk("rst_ack", 0, {31'b0, bus.Sl_xferAck}, 32'd0);
        chk("rst_dbus", 0, bus.Sl_DBus, 32'd0);
        chk("rst_frz", 0, {31'b0, ufrz}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vl.size(); i++) begin
            unique case (vl[i].kind)
                K_RD:  xfer(1'b1, vl[i].addr, vl[i].be, vl[i].wd,
                            vl[i].cap, vl[i].cd, vl[i].exp, i);
                K_WR:  xfer(1'b0, vl[i].addr, vl[i].be, vl[i].wd,
                            vl[i].cap, vl[i].cd, vl[i].exp, i);
                K_CAP: capture(vl[i].cd);
                K_NAK: noack(vl[i].addr, i);
                default: begin
                    @(negedge clk);
                    chk("freeze", i, {31'b0, ufrz}, vl[i].exp);
                end
            endcase
        end

        // Held select on STATUS: ack pattern 1,0,1,0, two reads of {0,new}.
        @(negedge clk);
        bus.OPB_ABus   = A_STAT;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        sbq.push_back('{v: 32'h1, id: 100});
        sbq.push_back('{v: 32'h1, id: 101});
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("held_ack", 110 + k, {31'b0, bus.Sl_xferAck},
                (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus.OPB_select = 1'b0;

        // Select withdrawn before the edge: no ack.
        @(negedge clk);
        bus.OPB_ABus   = A_STAT;
        bus.OPB_select = 1'b1;
        #2;
        bus.OPB_select = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_ack", 120, {31'b0, bus.Sl_xferAck}, 32'd0);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        xfer(1'b1, A_CNT, 4'hF, 0, 0, 0, 32'hFFFF_FFFF, 130);
        capture(32'h5A5A5A5A);
        xfer(1'b1, A_CNT, 4'hF, 0, 0, 0, 32'h0, 131);

        // Reset mid-transfer: ack and state drop at once.
        xfer(1'b0, A_CTRL, 4'b0001, 32'h1, 0, 0, 0, 140);
        @(negedge clk);
        bus.OPB_ABus   = A_STAT;
        bus.OPB_RNW    = 1'b1;
        bus.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", 141, {31'b0, bus.Sl_xferAck}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 142, {31'b0, bus.Sl_xferAck}, 32'd0);
        chk("mid_rst_dbus", 143, bus.Sl_DBus, 32'd0);
        chk("mid_rst_frz", 144, {31'b0, ufrz}, 32'd0);
        @(negedge clk);
        bus.OPB_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, A_STAT, 4'hF, 0, 0, 0, 32'h0, 145);
        xfer(1'b1, A_CNT,  4'hF, 0, 0, 0, 32'h0, 146);
        xfer(1'b1, A_DATA, 4'hF, 0, 0, 0, 32'h0, 147);

        repeat (2) @(negedge clk);
        chk("sb_empty", 150, sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
